// File: rtl/db_req_arbiter.sv
// db_req_arbiter: shares one key-value DB lookup port among NREQ parsers.
// Each parser pulse is captured in a one-entry slot. Slots are granted
// round-robin, one lookup at a time, and the DB reply (or a forced timeout)
// is routed back to the granted requester.
// Optional feature: define DB_ARB_STATS_EN to add saturating drop/timeout
// statistics counters (stat_drop_cnt, stat_timeout_cnt).
module db_req_arbiter #(
  parameter int NREQ     = 4,
  parameter int KEY_SIZE = 96,
  parameter int FLAG_W   = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clk156,
  input  logic                     eth_rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*KEY_SIZE-1:0] req_key,
  input  logic [NREQ*FLAG_W-1:0]   req_flag,
  output logic [NREQ-1:0]          resp_valid,
  output logic [FLAG_W-1:0]        resp_flag,
  output logic                     resp_timeout,
  output logic [NREQ-1:0]          req_drop,
  output logic                     busy,
  output logic [KEY_SIZE-1:0]      db_in_key,
  output logic [FLAG_W-1:0]        db_in_flag,
  output logic                     db_in_valid,
  input  logic                     db_out_valid,
  input  logic [FLAG_W-1:0]        db_out_flag
`ifdef DB_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       stat_drop_cnt,
  output logic [15:0]              stat_timeout_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [PW-1:0]       r_rrPtr;
  logic [PW-1:0]       r_grant;
  logic [15:0]         r_timer;
  logic [NREQ-1:0]     r_pend;
  logic [KEY_SIZE-1:0] r_slotKey  [NREQ];
  logic [FLAG_W-1:0]   r_slotFlag [NREQ];

  logic                w_found;
  logic [PW-1:0]       w_gIdx;
  logic [PW:0]         w_sum;
  logic [PW-1:0]       w_idx;
  logic                w_grantNow;
  logic [NREQ-1:0]     w_grantVec;
  logic [NREQ-1:0]     w_drop;
  logic                w_timeoutHit;

  // Pick the first pending slot at or after the round-robin pointer (wrapping).
  always_comb begin
    w_found = 1'b0;
    w_gIdx  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rrPtr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) begin
        w_sum = w_sum - (PW+1)'(NREQ);
      end
      w_idx = w_sum[PW-1:0];
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_gIdx  = w_idx;
      end
    end
  end

  // Decode this cycle's grant and the slot-overflow and timeout events.
  always_comb begin
    w_grantNow = (r_state == S_IDLE) && w_found;
    w_grantVec = '0;
    if (w_grantNow) begin
      w_grantVec[w_gIdx] = 1'b1;
    end
    w_drop       = req_valid & r_pend & ~w_grantVec;
    w_timeoutHit = (r_state == S_WAIT) && !db_out_valid &&
                   (r_timer == 16'(TIMEOUT - 1));
  end

  // Slot storage: an empty slot, or one being granted this cycle, takes the new request.
  always_ff @(posedge clk156) begin
    for (int i = 0; i < NREQ; i++) begin
      if (!eth_rst && req_valid[i] && (!r_pend[i] || w_grantVec[i])) begin
        r_slotKey[i]  <= req_key[i*KEY_SIZE +: KEY_SIZE];
        r_slotFlag[i] <= req_flag[i*FLAG_W +: FLAG_W];
      end
    end
  end

  // Pending flags (a new pulse beats the grant clear) and the drop pulse.
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      r_pend   <= '0;
      req_drop <= '0;
    end else begin
      r_pend   <= req_valid | (r_pend & ~w_grantVec);
      req_drop <= w_drop;
    end
  end

  // Arbitration FSM with registered DB-side and reply-side outputs.
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      r_state      <= S_IDLE;
      r_rrPtr      <= '0;
      r_grant      <= '0;
      r_timer      <= '0;
      db_in_key    <= '0;
      db_in_flag   <= '0;
      db_in_valid  <= 1'b0;
      resp_valid   <= '0;
      resp_flag    <= '0;
      resp_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      db_in_valid  <= 1'b0;
      resp_valid   <= '0;
      resp_flag    <= '0;
      resp_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_gIdx;
            db_in_key   <= r_slotKey[w_gIdx];
            db_in_flag  <= r_slotFlag[w_gIdx];
            r_rrPtr     <= (w_gIdx == PW'(NREQ - 1)) ? '0 : w_gIdx + 1'b1;
            db_in_valid <= 1'b1;
            busy        <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          busy    <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 16'd1;
          if (db_out_valid) begin
            resp_valid[r_grant] <= 1'b1;
            resp_flag           <= db_out_flag;
            busy                <= 1'b0;
            r_state             <= S_IDLE;
          end else if (w_timeoutHit) begin
            resp_valid[r_grant] <= 1'b1;
            resp_timeout        <= 1'b1;
            busy                <= 1'b0;
            r_state             <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef DB_ARB_STATS_EN
  // Saturating event counters, updated on the same edge that raises the event pulse.
  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      stat_drop_cnt    <= '0;
      stat_timeout_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_drop[i] && (stat_drop_cnt[i*16 +: 16] != 16'hFFFF)) begin
          stat_drop_cnt[i*16 +: 16] <= stat_drop_cnt[i*16 +: 16] + 16'd1;
        end
      end
      if (w_timeoutHit && (stat_timeout_cnt != 16'hFFFF)) begin
        stat_timeout_cnt <= stat_timeout_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_db_req_arbiter.sv
// Bench for db_req_arbiter: directed vectors push expected DB issues, replies
// and drops (with their expected cycle) into queues; a monitor on the falling
// edge pops and compares whenever the DUT raises the matching strobe.
`timescale 1ns/1ps
module tb_db_req_arbiter;
  localparam int NREQ     = 4;
  localparam int KEY_SIZE = 96;
  localparam int FLAG_W   = 4;
  localparam int TIMEOUT  = 8;

  logic                     clk156 = 1'b0;
  logic                     eth_rst = 1'b1;
  logic [NREQ-1:0]          req_valid = '0;
  logic [NREQ*KEY_SIZE-1:0] req_key = '0;
  logic [NREQ*FLAG_W-1:0]   req_flag = '0;
  logic [NREQ-1:0]          resp_valid;
  logic [FLAG_W-1:0]        resp_flag;
  logic                     resp_timeout;
  logic [NREQ-1:0]          req_drop;
  logic                     busy;
  logic [KEY_SIZE-1:0]      db_in_key;
  logic [FLAG_W-1:0]        db_in_flag;
  logic                     db_in_valid;
  logic                     db_out_valid = 1'b0;
  logic [FLAG_W-1:0]        db_out_flag = '0;
`ifdef DB_ARB_STATS_EN
  logic [NREQ*16-1:0]       stat_drop_cnt;
  logic [15:0]              stat_timeout_cnt;
`endif

  db_req_arbiter #(
    .NREQ(NREQ), .KEY_SIZE(KEY_SIZE), .FLAG_W(FLAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk156(clk156), .eth_rst(eth_rst),
    .req_valid(req_valid), .req_key(req_key), .req_flag(req_flag),
    .resp_valid(resp_valid), .resp_flag(resp_flag), .resp_timeout(resp_timeout),
    .req_drop(req_drop), .busy(busy),
    .db_in_key(db_in_key), .db_in_flag(db_in_flag), .db_in_valid(db_in_valid),
    .db_out_valid(db_out_valid), .db_out_flag(db_out_flag)
`ifdef DB_ARB_STATS_EN
    , .stat_drop_cnt(stat_drop_cnt), .stat_timeout_cnt(stat_timeout_cnt)
`endif
  );

  // 10 ns clock
  always #5 clk156 = ~clk156;

  // Cycle stamp used for latency expectations
  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  typedef struct { logic [KEY_SIZE-1:0] key; logic [FLAG_W-1:0] flag; int at; } issue_t;
  typedef struct { logic [NREQ-1:0] vec; logic [FLAG_W-1:0] flag; logic to; int at; } resp_t;
  typedef struct { logic [NREQ-1:0] vec; int at; } drop_t;

  issue_t issueQ[$];
  resp_t  respQ[$];
  drop_t  dropQ[$];

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [127:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endtask

  function automatic logic [KEY_SIZE-1:0] mkKey(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {w, ~w, w ^ 32'h5A5A_5A5A};
  endfunction

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [KEY_SIZE-1:0] key, input logic [FLAG_W-1:0] flag);
    req_valid[idx] = 1'b1;
    req_key[idx*KEY_SIZE +: KEY_SIZE] = key;
    req_flag[idx*FLAG_W +: FLAG_W] = flag;
  endtask

  task automatic pushIssue(input logic [KEY_SIZE-1:0] key, input logic [FLAG_W-1:0] flag, input int at);
    issue_t e;
    e.key = key; e.flag = flag; e.at = at;
    issueQ.push_back(e);
  endtask

  task automatic pushResp(input logic [NREQ-1:0] vec, input logic [FLAG_W-1:0] flag, input logic to, input int at);
    resp_t e;
    e.vec = vec; e.flag = flag; e.to = to; e.at = at;
    respQ.push_back(e);
  endtask

  task automatic pushDrop(input logic [NREQ-1:0] vec, input int at);
    drop_t e;
    e.vec = vec; e.at = at;
    dropQ.push_back(e);
  endtask

  task automatic doReset();
    eth_rst = 1'b1;
    req_valid = '0;
    db_out_valid = 1'b0;
    repeat (2) tick();
    eth_rst = 1'b0;
    tick();
  endtask

  task automatic waitIssue();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (db_in_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_issue: got no db_in_valid expected one within 40 cycles");
    end
  endtask

  // Monitor: compare every DUT strobe against the head of its expectation queue
  always @(negedge clk156) begin
    if (db_in_valid) begin
      if (issueQ.size() == 0) reportUnexpected("issue", 128'(db_in_key));
      else begin
        issue_t e;
        e = issueQ.pop_front();
        checkOutput("issue_key", 128'(db_in_key), 128'(e.key));
        checkOutput("issue_flag", 128'(db_in_flag), 128'(e.flag));
        checkOutput("issue_cycle", 128'(cyc), 128'(e.at));
      end
    end
    if (resp_valid != '0) begin
      if (respQ.size() == 0) reportUnexpected("resp", 128'(resp_valid));
      else begin
        resp_t e;
        e = respQ.pop_front();
        checkOutput("resp_vec", 128'(resp_valid), 128'(e.vec));
        checkOutput("resp_flag", 128'(resp_flag), 128'(e.flag));
        checkOutput("resp_timeout", 128'(resp_timeout), 128'(e.to));
        checkOutput("resp_cycle", 128'(cyc), 128'(e.at));
      end
    end else if (resp_flag != '0 || resp_timeout) begin
      reportUnexpected("resp_idle_outputs", 128'({resp_timeout, resp_flag}));
    end
    if (req_drop != '0) begin
      if (dropQ.size() == 0) reportUnexpected("drop", 128'(req_drop));
      else begin
        drop_t e;
        e = dropQ.pop_front();
        checkOutput("drop_vec", 128'(req_drop), 128'(e.vec));
        checkOutput("drop_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  // Safety net in case the stimulus itself stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  int t;

  initial begin
    // Reset state
    repeat (2) tick();
    checkOutput("reset_outputs", 128'({resp_valid, resp_flag, resp_timeout, req_drop, busy, db_in_valid}), 128'(0));
    checkOutput("reset_db_key", 128'({db_in_key, db_in_flag}), 128'(0));
    eth_rst = 1'b0;
    tick();

    // 1: single request on requester 2
    $display("[TB] test 1 single request");
    t = cyc;
    pushIssue({12{8'hA5}}, 4'b0011, t + 2);
    pushResp(4'b0100, 4'b0100, 1'b0, t + 6);
    applyStimulus(2, {12{8'hA5}}, 4'b0011);
    tick(); req_valid = '0;
    tick();
    checkOutput("busy_in_issue", 128'(busy), 128'(1));
    repeat (3) tick();
    db_out_valid = 1'b1; db_out_flag = 4'b0100;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    tick();
    checkOutput("busy_after_reply", 128'(busy), 128'(0));
    checkOutput("db_key_held", 128'(db_in_key), 128'({12{8'hA5}}));
    repeat (2) tick();

    // 2: round-robin from a fresh pointer
    $display("[TB] test 2 round robin");
    doReset();
    t = cyc;
    for (int i = 0; i < NREQ; i++) begin
      pushIssue(mkKey(i), 4'(i + 1), t + 2 + 4 * i);
      pushResp(4'(1 << i), 4'(i + 5), 1'b0, t + 5 + 4 * i);
      applyStimulus(i, mkKey(i), 4'(i + 1));
    end
    tick(); req_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      waitIssue();
      repeat (2) tick();
      db_out_valid = 1'b1; db_out_flag = 4'(k + 5);
      tick(); db_out_valid = 1'b0; db_out_flag = '0;
    end
    repeat (3) tick();

    // 3: second pulse on a full slot is dropped, first key kept
    $display("[TB] test 3 drop");
    t = cyc;
    pushIssue(mkKey(20), 4'h1, t + 2);
    pushDrop(4'b0010, t + 5);
    pushResp(4'b0001, 4'h9, 1'b0, t + 6);
    pushIssue(mkKey(21), 4'h5, t + 7);
    pushResp(4'b0010, 4'hC, 1'b0, t + 10);
    applyStimulus(0, mkKey(20), 4'h1);
    tick(); req_valid = '0;
    repeat (2) tick();
    applyStimulus(1, mkKey(21), 4'h5);
    tick();
    applyStimulus(1, mkKey(22), 4'h6);
    tick(); req_valid = '0;
    db_out_valid = 1'b1; db_out_flag = 4'h9;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    repeat (3) tick();
    db_out_valid = 1'b1; db_out_flag = 4'hC;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    repeat (2) tick();
`ifdef DB_ARB_STATS_EN
    checkOutput("stat_drop_1", 128'(stat_drop_cnt[16 +: 16]), 128'(1));
    checkOutput("stat_drop_0", 128'(stat_drop_cnt[0 +: 16]), 128'(0));
`endif

    // 4: timeout on requester 2, then requester 3 is granted
    $display("[TB] test 4 timeout");
    t = cyc;
    pushIssue(mkKey(30), 4'h1, t + 2);
    pushResp(4'b0100, 4'h0, 1'b1, t + 11);
    pushIssue(mkKey(31), 4'h2, t + 12);
    pushResp(4'b1000, 4'hF, 1'b0, t + 15);
    applyStimulus(2, mkKey(30), 4'h1);
    applyStimulus(3, mkKey(31), 4'h2);
    tick(); req_valid = '0;
    repeat (13) tick();
    db_out_valid = 1'b1; db_out_flag = 4'hF;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    repeat (3) tick();
`ifdef DB_ARB_STATS_EN
    checkOutput("stat_timeout", 128'(stat_timeout_cnt), 128'(1));
`endif

    // 5: stray reply in IDLE, then reset during WAIT
    $display("[TB] test 5 stray reply and reset");
    db_out_valid = 1'b1; db_out_flag = 4'h7;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    tick();
    checkOutput("stray_busy", 128'(busy), 128'(0));
    checkOutput("stray_resp", 128'(resp_valid), 128'(0));
    t = cyc;
    pushIssue(mkKey(40), 4'h3, t + 2);
    applyStimulus(0, mkKey(40), 4'h3);
    applyStimulus(1, mkKey(41), 4'h4);
    tick(); req_valid = '0;
    repeat (3) tick();
    checkOutput("busy_in_wait", 128'(busy), 128'(1));
    eth_rst = 1'b1;
    tick(); eth_rst = 1'b0;
    checkOutput("reset_mid_busy", 128'(busy), 128'(0));
    checkOutput("reset_mid_outputs", 128'({resp_valid, db_in_valid, req_drop}), 128'(0));
    db_out_valid = 1'b1; db_out_flag = 4'hA;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    repeat (6) tick();
    checkOutput("after_reset_idle", 128'(busy), 128'(0));

    // 6: new pulse on the grant cycle of requester 3
    $display("[TB] test 6 set wins over clear");
    t = cyc;
    pushIssue(mkKey(50), 4'h2, t + 2);
    pushResp(4'b1000, 4'h3, 1'b0, t + 5);
    pushIssue(mkKey(51), 4'h7, t + 6);
    pushResp(4'b1000, 4'h6, 1'b0, t + 9);
    applyStimulus(3, mkKey(50), 4'h2);
    tick();
    applyStimulus(3, mkKey(51), 4'h7);
    tick(); req_valid = '0;
    repeat (2) tick();
    db_out_valid = 1'b1; db_out_flag = 4'h3;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    repeat (3) tick();
    db_out_valid = 1'b1; db_out_flag = 4'h6;
    tick(); db_out_valid = 1'b0; db_out_flag = '0;
    repeat (4) tick();
`ifdef DB_ARB_STATS_EN
    checkOutput("stat_drop_3", 128'(stat_drop_cnt[48 +: 16]), 128'(0));
`endif

    // Every expectation must have been consumed
    checkOutput("issue_left", 128'(issueQ.size()), 128'(0));
    checkOutput("resp_left", 128'(respQ.size()), 128'(0));
    checkOutput("drop_left", 128'(dropQ.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
